prog_mem_loader: RTL and testbench
==================================

Name: prog_mem_loader

Overview:
Writer side of the instruction-fetch interface for the 4-bit CPU. It owns the 16x8 program memory, accepts a program as a stream of bytes over a valid/ready handshake, and serves synchronous reads to the fetch stage. While a program is loading it holds the CPU via cpu_hold, and it releases the CPU once the load completes.

Parameters:
ADDR_W, 4, address width of program memory
DATA_W, 8, instruction width
DEPTH, 16, number of instruction words (2**ADDR_W)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
load_start  in  1  request a (re)load; sampled in IDLE and RUN only
wr_valid  in  1  loader byte valid
wr_data  in  DATA_W  loader byte (instruction)
wr_last  in  1  qualifies wr_data as final word of program
wr_ready  out  1  block accepts byte this cycle
rd_adrs  in  ADDR_W  fetch address from CPU
rd_inst  out  DATA_W  instruction at rd_adrs, registered
cpu_hold  out  1  CPU must stall/keep PC at 0 while high
load_done  out  1  one-cycle pulse when a load finishes
word_count  out  ADDR_W+1  number of words written by last/current load

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - All memory words=0x00.
  - rd_inst=0x00, wr_ready=0, cpu_hold=1, load_done=0, word_count=0, internal wptr=0.
- States: IDLE, LOAD, RUN. All outputs are registered except wr_ready and cpu_hold, which decode state combinationally.
- IDLE:
  - cpu_hold=1, wr_ready=0.
  - load_start=1 -> LOAD next cycle; wptr<=0, word_count<=0.
- LOAD:
  - cpu_hold=1, wr_ready=1.
  - Transfer occurs when wr_valid&wr_ready: mem[wptr]<=wr_data, wptr<=wptr+1, word_count<=word_count+1.
  - Transfer with wr_last=1, or transfer into address DEPTH-1 -> RUN next cycle; load_done=1 for exactly that next cycle.
  - wptr does not wrap past DEPTH-1. Bytes beyond the last address are impossible because the transition is forced.
  - Words not written in this load keep their previous contents.
  - load_start is ignored in LOAD.
  - wr_valid=0 cycles are stalls; there is no timeout.
- RUN:
  - cpu_hold=0, wr_ready=0. wr_valid is ignored and memory is unchanged.
  - load_start=1 -> LOAD next cycle; wptr<=0, word_count<=0, cpu_hold=1 from that cycle.
- Read port (all states):
  - rd_inst <= mem[rd_adrs] every cycle: 1-cycle latency, full 4-bit address, no wrap logic needed.
  - Same-cycle write and read of the same address returns the OLD data; the new data appears on the following read.
- load_done is never high in two consecutive cycles.
- word_count saturates naturally at DEPTH (5 bits hold 16).
- Reset mid-LOAD: immediate return to IDLE and memory cleared. A partial program is never exposed with cpu_hold=0.

Test Plan:
- Reset then idle 5 cycles -> cpu_hold=1, wr_ready=0, rd_inst=0x00 for every rd_adrs 0..15, load_done never high.
- Full load: load_start pulse, stream 16 bytes 0xB1,0xB2..0xC0 with wr_valid held high, wr_last=0.
  - wr_ready=1 during the 16 transfers.
  - load_done pulses once on the cycle after byte 16; cpu_hold=0 from that cycle; word_count=16.
  - Reading addr 0 gives 0xB1 and addr 15 gives 0xC0, each one cycle after presenting the address.
- Short program with stalls: reload with 3 bytes 0x31,0xE0,0xF0 (last has wr_last=1) and wr_valid low for 2 cycles between bytes.
  - word_count=3, load_done pulses once.
  - addr0..2 read 0x31,0xE0,0xF0; addr3 still reads 0xB4 from the previous load.
- Read-during-write: in LOAD, hold rd_adrs=0 while writing 0x55 to addr0 (old 0x31).
  - rd_inst=0x31 on the next cycle, 0x55 on the cycle after.
- load_start during LOAD asserted mid-stream -> no effect; wptr continues; the final load matches the stream.
- Async reset mid-LOAD after 5 bytes: assert rst=0 between clock edges.
  - Outputs go to reset values immediately without waiting for a clock edge.
  - After release the state is IDLE and all reads return 0x00.

Source files
------------

// File: rtl/prog_mem_loader.sv
// prog_mem_loader: 16x8 program memory loaded over a valid/ready byte stream, holding the CPU until the load completes.
module prog_mem_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] rd_adrs,
  output logic [DATA_W-1:0] rd_inst,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t            state_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q;
  logic [DATA_W-1:0] rd_inst_q;
  logic              load_done_q;
  logic [ADDR_W:0]   wc_q;
  logic              xfer, fin;
  assign wr_ready   = state_q == LOAD;
  assign cpu_hold   = state_q != RUN;
  assign xfer       = wr_valid & wr_ready;
  // the top address forces completion, so wptr never needs to wrap
  assign fin        = xfer & (wr_last | (wptr_q == ADDR_W'(DEPTH-1)));
  assign rd_inst    = rd_inst_q;
  assign load_done  = load_done_q;
  assign word_count = wc_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q      <= '0;
      rd_inst_q   <= '0;
      load_done_q <= 1'b0;
      wc_q        <= '0;
    end else begin
      rd_inst_q   <= mem_q[rd_adrs];
      load_done_q <= fin;
      if (state_q != LOAD && load_start) begin
        state_q <= LOAD;
        wptr_q  <= '0;
        wc_q    <= '0;
      end
      if (xfer) begin
        mem_q[wptr_q] <= wr_data;
        wc_q          <= wc_q + (ADDR_W+1)'(1);
        if (!fin) wptr_q <= wptr_q + ADDR_W'(1);
      end
      if (fin) state_q <= RUN;
    end
  end
endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: randomized loads checked against an array model of program memory.
module tb_prog_mem_loader;
  localparam int D = 16;
  logic       clk = 0, rst = 0, load_start = 0, wr_valid = 0, wr_last = 0;
  logic [7:0] wr_data = 0;
  logic [3:0] rd_adrs = 0;
  logic       wr_ready, cpu_hold, load_done;
  logic [7:0] rd_inst;
  logic [4:0] word_count;
  int         checks = 0, errors = 0;
  logic [7:0] exp_mem [D];
  logic [7:0] prog [D];

  prog_mem_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready), .rd_adrs(rd_adrs),
    .rd_inst(rd_inst), .cpu_hold(cpu_hold), .load_done(load_done), .word_count(word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic read_all;
    for (int a = 0; a < D; a++) begin
      rd_adrs = 4'(a);
      tick;
      checks++;
      if (rd_inst !== exp_mem[a]) begin
        errors++;
        $display("FAIL read addr %0d: got %h expected %h", a, rd_inst, exp_mem[a]);
      end
    end
  endtask

  task automatic load_prog(input int n, input bit use_last, input int stall, input int ls_at);
    load_start = 1;
    tick;
    load_start = 0;
    checks++;
    if (wr_ready !== 1'b1 || cpu_hold !== 1'b1 || word_count !== 5'd0) begin
      errors++;
      $display("FAIL load_entry: ready=%b hold=%b wc=%0d expected 1 1 0", wr_ready, cpu_hold, word_count);
    end
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        int ns;
        ns = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
        for (int s = 0; s < ns; s++) begin
          wr_valid = 0;
          tick;
          checks++;
          if (load_done !== 1'b0 || wr_ready !== 1'b1 || word_count !== 5'(i)) begin
            errors++;
            $display("FAIL stall: done=%b ready=%b wc=%0d expected 0 1 %0d", load_done, wr_ready, word_count, i);
          end
        end
      end
      wr_valid   = 1;
      wr_data    = prog[i];
      wr_last    = use_last && (i == n - 1);
      load_start = (i == ls_at);
      tick;
      exp_mem[i] = prog[i];
      if (i < n - 1) begin
        checks++;
        if (load_done !== 1'b0 || cpu_hold !== 1'b1 || word_count !== 5'(i + 1)) begin
          errors++;
          $display("FAIL mid_load: done=%b hold=%b wc=%0d expected 0 1 %0d", load_done, cpu_hold, word_count, i + 1);
        end
      end
    end
    wr_valid   = 0;
    wr_last    = 0;
    load_start = 0;
    checks++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b0 || wr_ready !== 1'b0 || word_count !== 5'(n)) begin
      errors++;
      $display("FAIL load_finish: done=%b hold=%b ready=%b wc=%0d expected 1 0 0 %0d",
               load_done, cpu_hold, wr_ready, word_count, n);
    end
    tick;
    checks++;
    if (load_done !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b hold=%b expected 0 0", load_done, cpu_hold);
    end
  endtask

  task automatic test_reset;
    rst = 0;
    repeat (3) tick;
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < D; i++) exp_mem[i] = 8'h00;
    for (int c = 0; c < 5; c++) begin
      tick;
      checks++;
      if (cpu_hold !== 1'b1 || wr_ready !== 1'b0 || load_done !== 1'b0 || word_count !== 5'd0) begin
        errors++;
        $display("FAIL idle: hold=%b ready=%b done=%b wc=%0d expected 1 0 0 0", cpu_hold, wr_ready, load_done, word_count);
      end
    end
    read_all;
  endtask

  task automatic test_full_load;
    for (int i = 0; i < D; i++) prog[i] = 8'hB1 + 8'(i);
    load_prog(16, 0, 0, -1);
    read_all;
  endtask

  task automatic test_short_stalls;
    prog[0] = 8'h31; prog[1] = 8'hE0; prog[2] = 8'hF0;
    load_prog(3, 1, 2, -1);
    read_all;
  endtask

  task automatic test_read_during_write;
    rd_adrs    = 0;
    load_start = 1;
    tick;
    load_start = 0;
    wr_valid   = 1;
    wr_data    = 8'h55;
    wr_last    = 1;
    tick;
    wr_valid   = 0;
    wr_last    = 0;
    checks++;
    if (rd_inst !== 8'h31 || load_done !== 1'b1 || word_count !== 5'd1) begin
      errors++;
      $display("FAIL rdw_old: inst=%h done=%b wc=%0d expected 31 1 1", rd_inst, load_done, word_count);
    end
    tick;
    checks++;
    if (rd_inst !== 8'h55) begin
      errors++;
      $display("FAIL rdw_new: inst=%h expected 55", rd_inst);
    end
    exp_mem[0] = 8'h55;
  endtask

  task automatic test_load_start_ignored;
    for (int i = 0; i < 8; i++) prog[i] = 8'($urandom);
    load_prog(8, 1, 1, 4);
    read_all;
  endtask

  task automatic test_run_ignores_write;
    wr_valid = 1;
    for (int c = 0; c < 4; c++) begin
      wr_data = 8'($urandom);
      tick;
      checks++;
      if (wr_ready !== 1'b0 || cpu_hold !== 1'b0 || load_done !== 1'b0) begin
        errors++;
        $display("FAIL run_idle: ready=%b hold=%b done=%b expected 0 0 0", wr_ready, cpu_hold, load_done);
      end
    end
    wr_valid = 0;
    read_all;
  endtask

  task automatic test_random_loads;
    for (int k = 0; k < 6; k++) begin
      int  n;
      bit  ul;
      n  = int'($urandom_range(1, 16));
      ul = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) prog[i] = 8'($urandom);
      load_prog(n, ul, -1, -1);
      read_all;
    end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 5; i++) prog[i] = 8'($urandom) | 8'h01;
    load_start = 1;
    tick;
    load_start = 0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1;
      wr_data  = prog[i];
      tick;
    end
    wr_valid = 0;
    rd_adrs  = 0;
    tick;
    checks++;
    if (rd_inst !== prog[0] || word_count !== 5'd5 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: inst=%h wc=%0d hold=%b expected %h 5 1", rd_inst, word_count, cpu_hold, prog[0]);
    end
    #2 rst = 0;
    #1;
    checks++;
    if (rd_inst !== 8'h00 || cpu_hold !== 1'b1 || wr_ready !== 1'b0 || word_count !== 5'd0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: inst=%h hold=%b ready=%b wc=%0d done=%b expected 00 1 0 0 0",
               rd_inst, cpu_hold, wr_ready, word_count, load_done);
    end
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < D; i++) exp_mem[i] = 8'h00;
    tick;
    checks++;
    if (wr_ready !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle: ready=%b hold=%b expected 0 1", wr_ready, cpu_hold);
    end
    read_all;
  endtask

  initial begin
    test_reset;
    test_full_load;
    test_short_stalls;
    test_read_during_write;
    test_load_start_ignored;
    test_run_ignores_write;
    test_random_loads;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
